pulse_period_meter: RTL and testbench

- Receive-side companion to the team's modulo-k rollover counters.
- Observes a single-cycle pulse train, such as a counter's rollover output, and recovers the period k in clock cycles.
- Declares lock after repeated identical periods, and flags mismatches and timeouts.
- Used to check or recover k from a remote counter's rollover line.

---
 rtl/pulse_period_meter.sv | 125 ++++++++++++
 tb/tb_pulse_period_meter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Recovers the period of a pulse train (e.g. a modulo-k counter's rollover line),
// declares lock after LOCK_COUNT equal periods, and flags mismatches and timeouts.
module pulse_period_meter #(
  parameter int N          = 8,
  parameter int LOCK_COUNT = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_pulse,
  output logic [N-1:0] o_period,
  output logic         o_valid,
  output logic         o_locked,
  output logic         o_mismatch,
  output logic         o_timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [N-1:0] GAP_MAX  = '1;
  localparam logic [N-1:0] GAP_ONE  = N'(1);
  localparam logic [3:0]   LOCK_CNT = 4'(LOCK_COUNT);

  state_t       state_q, state_d;
  logic [N-1:0] gap_q, gap_d;
  logic [N-1:0] ref_q, ref_d;
  logic [N-1:0] period_q, period_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   cnt_next;
  logic         valid_q, valid_d;
  logic         locked_q, locked_d;
  logic         mismatch_q, mismatch_d;
  logic         timeout_q, timeout_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      ref_q      <= '0;
      period_q   <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      ref_q      <= ref_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      mismatch_q <= mismatch_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    ref_d      = ref_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    cnt_next   = cnt_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    mismatch_d = 1'b0;
    timeout_d  = 1'b0;

    if (state_q == IDLE) begin
      if (i_pulse) begin
        gap_d   = GAP_ONE;
        state_d = MEASURE;
      end
    end else if (i_pulse) begin
      // A pulse always wins over saturation, so a period of 2^N-1 is measured.
      gap_d    = GAP_ONE;
      period_d = gap_q;
      valid_d  = 1'b1;
      if (state_q == MEASURE) begin
        if (gap_q == ref_q) begin
          cnt_next = cnt_q + 4'd1;
        end else begin
          ref_d    = gap_q;
          cnt_next = 4'd1;
        end
        cnt_d = cnt_next;
        if (cnt_next == LOCK_CNT) begin
          state_d  = LOCKED;
          locked_d = 1'b1;
        end
      end else if (gap_q != ref_q) begin
        mismatch_d = 1'b1;
        ref_d      = gap_q;
        cnt_d      = 4'd1;
        if (LOCK_CNT == 4'd1) begin
          locked_d = 1'b1;
        end else begin
          locked_d = 1'b0;
          state_d  = MEASURE;
        end
      end
    end else if (gap_q == GAP_MAX) begin
      timeout_d = 1'b1;
      locked_d  = 1'b0;
      state_d   = IDLE;
      gap_d     = '0;
      ref_d     = '0;
      cnt_d     = '0;
    end else begin
      gap_d = gap_q + GAP_ONE;
    end
  end

  assign o_period   = period_q;
  assign o_valid    = valid_q;
  assign o_locked   = locked_q;
  assign o_mismatch = mismatch_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: an N=8 and an N=4 instance driven by directed pulse
// schedules, with expected output events queued per instance and popped by monitors.
module tb_pulse_period_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       r8, p8, v8, l8, m8, t8;
  logic [7:0] per8;
  logic       r4, p4, v4, l4, m4, t4;
  logic [3:0] per4;

  int checks = 0;
  int errors = 0;

  // Event record: {cycle[15:0], period[7:0], valid, locked, mismatch, timeout}
  logic [27:0] exp8_q[$];
  logic [27:0] exp4_q[$];

  pulse_period_meter #(.N(8), .LOCK_COUNT(2)) u8 (
    .i_clk(clk), .i_reset(r8), .i_pulse(p8), .o_period(per8),
    .o_valid(v8), .o_locked(l8), .o_mismatch(m8), .o_timeout(t8)
  );

  pulse_period_meter #(.N(4), .LOCK_COUNT(2)) u4 (
    .i_clk(clk), .i_reset(r4), .i_pulse(p4), .o_period(per4),
    .o_valid(v4), .o_locked(l4), .o_mismatch(m4), .o_timeout(t4)
  );

  function automatic logic [27:0] mk(input int c, input int p, input logic v,
                                     input logic l, input logic m, input logic t);
    logic [15:0] c16;
    logic [7:0]  p8b;
    c16 = c[15:0];
    p8b = p[7:0];
    return {c16, p8b, v, l, m, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin : mon8
    logic [27:0] act, exp_r;
    if (v8 | m8 | t8) begin
      act = mk(cyc, int'(per8), v8, l8, m8, t8);
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("FAIL u8_event: unexpected actual=%h (cycle/period/v/l/m/t)", act);
      end else begin
        exp_r = exp8_q.pop_front();
        if (act !== exp_r) begin
          errors++;
          $display("FAIL u8_event: actual=%h required=%h", act, exp_r);
        end
      end
    end
  end

  always @(negedge clk) begin : mon4
    logic [27:0] act, exp_r;
    if (v4 | m4 | t4) begin
      act = mk(cyc, int'(per4), v4, l4, m4, t4);
      checks++;
      if (exp4_q.size() == 0) begin
        errors++;
        $display("FAIL u4_event: unexpected actual=%h (cycle/period/v/l/m/t)", act);
      end else begin
        exp_r = exp4_q.pop_front();
        if (act !== exp_r) begin
          errors++;
          $display("FAIL u4_event: actual=%h required=%h", act, exp_r);
        end
      end
    end
  end

  // Drivers: wait (on falling edges) until the cycle counter reaches c, then hold the pulse n cycles.
  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse8(input int c, input int n);
    at_cycle(c);
    p8 = 1'b1;
    repeat (n) @(negedge clk);
    p8 = 1'b0;
  endtask

  task automatic pulse4(input int c, input int n);
    at_cycle(c);
    p4 = 1'b1;
    repeat (n) @(negedge clk);
    p4 = 1'b0;
  endtask

  task automatic seq8();
    int b;
    b = cyc;
    // k=3 rollover train, then a mismatch and relock at 5
    pulse8(b + 3, 1);
    exp8_q.push_back(mk(b + 7, 3, 1, 0, 0, 0));
    pulse8(b + 6, 1);
    exp8_q.push_back(mk(b + 10, 3, 1, 1, 0, 0));
    pulse8(b + 9, 1);
    exp8_q.push_back(mk(b + 13, 3, 1, 1, 0, 0));
    pulse8(b + 12, 1);
    exp8_q.push_back(mk(b + 16, 3, 1, 1, 0, 0));
    pulse8(b + 15, 1);
    exp8_q.push_back(mk(b + 21, 5, 1, 0, 1, 0));
    pulse8(b + 20, 1);
    exp8_q.push_back(mk(b + 26, 5, 1, 1, 0, 0));
    pulse8(b + 25, 1);
    at_cycle(b + 30);
    chk("u8_locked_held", 32'(l8), 32'd1);

    r8 = 1'b1;
    @(negedge clk);
    r8 = 1'b0;
    b = cyc;
    // Continuous high input: period 1 every cycle after the first
    exp8_q.push_back(mk(b + 4, 1, 1, 0, 0, 0));
    for (int i = 5; i <= 8; i++) exp8_q.push_back(mk(b + i, 1, 1, 1, 0, 0));
    pulse8(b + 2, 6);
    at_cycle(b + 12);
    chk("u8_locked_before_reset", 32'(l8), 32'd1);
    #2;
    r8 = 1'b1;
    #1;
    chk("u8_async_reset", {23'd0, per8, v8, l8, m8, t8}, 32'd0);
    @(negedge clk);
    r8 = 1'b0;
    b = cyc;
    pulse8(b + 2, 1);
    exp8_q.push_back(mk(b + 7, 4, 1, 0, 0, 0));
    pulse8(b + 6, 1);
    exp8_q.push_back(mk(b + 11, 4, 1, 1, 0, 0));
    pulse8(b + 10, 1);
    at_cycle(b + 15);
    chk("u8_relocked", 32'(l8), 32'd1);
  endtask

  task automatic seq4();
    int b;
    b = cyc;
    // Single pulse then silence: one timeout, never a valid
    exp4_q.push_back(mk(b + 16, 0, 0, 0, 0, 1));
    pulse4(b, 1);
    at_cycle(b + 40);
    chk("u4_unlocked_after_timeout", 32'(l4), 32'd0);

    b = cyc;
    // Gap of exactly 15 is a period, not a timeout; then timeout from LOCKED
    pulse4(b, 1);
    exp4_q.push_back(mk(b + 16, 15, 1, 0, 0, 0));
    pulse4(b + 15, 1);
    exp4_q.push_back(mk(b + 31, 15, 1, 1, 0, 0));
    exp4_q.push_back(mk(b + 46, 15, 0, 0, 0, 1));
    pulse4(b + 30, 1);
    at_cycle(b + 48);
    chk("u4_period_held", 32'(per4), 32'd15);
    pulse4(b + 50, 1);
    at_cycle(b + 60);
    r4 = 1'b1;
    @(negedge clk);
    r4 = 1'b0;
  endtask

  initial begin
    p8 = 1'b0;
    p4 = 1'b0;
    r8 = 1'b1;
    r4 = 1'b1;
    repeat (3) @(negedge clk);
    chk("u8_reset_outputs", {23'd0, per8, v8, l8, m8, t8}, 32'd0);
    chk("u4_reset_outputs", {27'd0, per4, v4, l4, m4, t4}, 32'd0);
    r8 = 1'b0;
    r4 = 1'b0;
    fork
      seq8();
      seq4();
    join
    repeat (3) @(negedge clk);
    chk("u8_queue_drained", 32'(exp8_q.size()), 32'd0);
    chk("u4_queue_drained", 32'(exp4_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
